// File: rtl/reduce_sum_scheduler.sv
// Shared 16x8 value memory with two requesters: a writer that loads entries and
// a summer that runs a 16-cycle reduce-sum pass, arbitrated by alternating priority.
module reduce_sum_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SUM_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  input  logic              sum_req,
  output logic              sum_grant,
  output logic              sum_busy,
  output logic              sum_done,
  output logic [SUM_W-1:0]  sum_result,
  output logic [ADDR_W-1:0] mem_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   result_q, result_d;
  logic               prio_q, prio_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  // prio_q low favours the writer, high favours the summer; grants only in IDLE.
  assign wr_grant   = (state_q == IDLE) && wr_req  && (!sum_req || !prio_q);
  assign sum_grant  = (state_q == IDLE) && sum_req && (!wr_req  ||  prio_q);
  assign sum_busy   = (state_q != IDLE);
  assign sum_done   = (state_q == DONE);
  assign sum_result = result_q;
  assign mem_addr   = (state_q == ACCUM) ? cnt_q : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      prio_q   <= prio_d;
    end
  end

  // Writes only land while idle, so the memory is frozen for the whole pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_grant) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    prio_d   = prio_q;
    case (state_q)
      IDLE: begin
        if (sum_grant) begin
          state_d = CLEAR;
          prio_d  = 1'b0;
        end else if (wr_grant) begin
          prio_d  = 1'b1;
        end
      end
      CLEAR: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d = acc_q + {{(SUM_W-DATA_W){1'b0}}, mem_q[cnt_q]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reduce_sum_scheduler.sv
// Directed bench for reduce_sum_scheduler: loads, sums, arbitration, writes
// blocked during a pass and a reset that aborts a pass mid-way.
module tb_reduce_sum_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_grant;
  logic        sum_req;
  logic        sum_grant;
  logic        sum_busy;
  logic        sum_done;
  logic [11:0] sum_result;
  logic [3:0]  mem_addr;

  int checks = 0;
  int errors = 0;

  reduce_sum_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_grant   (wr_grant),
    .sum_req    (sum_req),
    .sum_grant  (sum_grant),
    .sum_busy   (sum_busy),
    .sum_done   (sum_done),
    .sum_result (sum_result),
    .mem_addr   (mem_addr)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Single lone write in IDLE; returns one cycle after the committing edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    wr_addr = addr;
    wr_data = data;
    wr_req  = 1'b1;
    #1;
    checkOutput("wr_grant_lone", 32'(wr_grant), 32'd1);
    nextCycle();
    wr_req = 1'b0;
  endtask

  // Full pass from grant to the first IDLE cycle; optionally raises a write
  // at ACCUM cycle 4 and holds it until it is granted after DONE.
  task automatic runSum(input logic [11:0] expected, input bit wrDuring);
    sum_req = 1'b1;
    #1;
    checkOutput("sum_grant", 32'(sum_grant), 32'd1);
    nextCycle();
    sum_req = 1'b0;
    checkOutput("busy_clear", 32'(sum_busy), 32'd1);
    checkOutput("addr_clear", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      if (wrDuring && i == 4) begin
        wr_addr = 4'd0;
        wr_data = 8'h55;
        wr_req  = 1'b1;
      end
      #1;
      checkOutput("mem_addr_accum", 32'(mem_addr), 32'(i));
      checkOutput("done_low_accum", 32'(sum_done), 32'd0);
      if (wrDuring && i >= 4) checkOutput("wr_blocked_accum", 32'(wr_grant), 32'd0);
    end
    nextCycle();
    checkOutput("sum_done", 32'(sum_done), 32'd1);
    checkOutput("sum_result", 32'(sum_result), 32'(expected));
    if (wrDuring) checkOutput("wr_blocked_done", 32'(wr_grant), 32'd0);
    nextCycle();
    checkOutput("done_pulse_end", 32'(sum_done), 32'd0);
    checkOutput("busy_idle", 32'(sum_busy), 32'd0);
    if (wrDuring) begin
      checkOutput("wr_grant_after_pass", 32'(wr_grant), 32'd1);
      nextCycle();
      wr_req = 1'b0;
      checkOutput("result_unaffected", 32'(sum_result), 32'(expected));
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    #2;
    checkOutput("rst_wr_grant", 32'(wr_grant), 32'd0);
    checkOutput("rst_sum_grant", 32'(sum_grant), 32'd0);
    checkOutput("rst_sum_busy", 32'(sum_busy), 32'd0);
    checkOutput("rst_sum_done", 32'(sum_done), 32'd0);
    checkOutput("rst_sum_result", 32'(sum_result), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sum_req = 1'b0;

    $display("[TB] reset and empty sum");
    resetDut();
    runSum(12'd0, 1'b0);

    $display("[TB] ramp values 1..16");
    for (int i = 0; i < 16; i++) applyStimulus(4'(i), 8'(i + 1));
    runSum(12'd136, 1'b0);

    $display("[TB] all entries 0xFF");
    for (int i = 0; i < 16; i++) applyStimulus(4'(i), 8'hFF);
    runSum(12'hFF0, 1'b0);

    $display("[TB] simultaneous requests after reset");
    resetDut();
    wr_addr = 4'd3;
    wr_data = 8'h10;
    wr_req  = 1'b1;
    sum_req = 1'b1;
    #1;
    checkOutput("conflict_wr_first", 32'(wr_grant), 32'd1);
    checkOutput("conflict_sum_wait", 32'(sum_grant), 32'd0);
    nextCycle();
    wr_req = 1'b0;
    #1;
    checkOutput("conflict_wr_done", 32'(wr_grant), 32'd0);
    checkOutput("conflict_sum_next", 32'(sum_grant), 32'd1);
    runSum(12'h010, 1'b0);

    $display("[TB] write requested during pass");
    runSum(12'h010, 1'b1);
    runSum(12'h065, 1'b0);

    $display("[TB] reset mid-pass");
    sum_req = 1'b1;
    #1;
    checkOutput("abort_sum_grant", 32'(sum_grant), 32'd1);
    nextCycle();
    sum_req = 1'b0;
    for (int i = 0; i < 6; i++) nextCycle();
    checkOutput("abort_at_addr5", 32'(mem_addr), 32'd5);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(sum_busy), 32'd0);
    checkOutput("abort_result", 32'(sum_result), 32'd0);
    checkOutput("abort_addr", 32'(mem_addr), 32'd0);
    checkOutput("abort_done", 32'(sum_done), 32'd0);
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      checkOutput("abort_no_done", 32'(sum_done), 32'd0);
      checkOutput("abort_idle", 32'(sum_busy), 32'd0);
    end
    runSum(12'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
